// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses and an optional first-word-fall-through read port.
module sync_fifo_ext #(
  parameter int unsigned data_width = 8,
  parameter int unsigned add_width  = 4,
  parameter bit          fwft       = 1'b0,
  parameter int unsigned af_thresh  = (1 << add_width) - 2,
  parameter int unsigned ae_thresh  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] data_in,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [data_width-1:0] data_out,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [add_width:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << add_width;
  localparam logic [add_width:0]   DEPTH_C = (add_width + 1)'(DEPTH);
  localparam logic [add_width:0]   AF_C    = (add_width + 1)'(af_thresh);
  localparam logic [add_width:0]   AE_C    = (add_width + 1)'(ae_thresh);
  localparam logic [add_width:0]   CNT_ONE = (add_width + 1)'(1);
  localparam logic [add_width-1:0] PTR_ONE = add_width'(1);

  if (af_thresh < 1 || af_thresh > DEPTH) begin : g_bad_af
    $error("sync_fifo_ext: af_thresh must lie in 1..depth");
  end
  if (ae_thresh > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_ext: ae_thresh must lie in 0..depth-1");
  end

  logic [data_width-1:0] r_mem [DEPTH];
  logic [add_width-1:0]  r_wr_ptr;
  logic [add_width-1:0]  r_rd_ptr;
  logic [add_width:0]    r_count;
  logic                  r_full;
  logic                  r_almost_full;
  logic                  r_empty;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [add_width:0]    w_count_nxt;

  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Flags are registered from next-count so no request input reaches a flag combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == DEPTH_C);
      r_almost_full  <= (w_count_nxt >= AF_C);
      r_empty        <= (w_count_nxt == '0);
      r_almost_empty <= (w_count_nxt <= AE_C);
      r_overflow     <= wr_en & r_full;
      r_underflow    <= rd_en & r_empty;
    end
  end

  if (fwft) begin : g_fwft
    assign data_out = r_mem[r_rd_ptr];
  end else begin : g_std
    logic [data_width-1:0] r_data_out;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data_out <= '0;
      end else if (w_rd_acc) begin
        r_data_out <= r_mem[r_rd_ptr];
      end
    end
    assign data_out = r_data_out;
  end

  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Scoreboard bench for sync_fifo_ext: three configurations driven in lockstep against
// queue-based reference models; a negedge monitor checks data and flags.
module tb_sync_fifo_ext;

  localparam int          DEP  [3] = '{16, 16, 8};
  localparam int          AFT  [3] = '{14, 14, 6};
  localparam int          AET  [3] = '{2, 2, 1};
  localparam bit          FW   [3] = '{1'b0, 1'b1, 1'b0};
  localparam logic [31:0] MASK [3] = '{32'h0000_00FF, 32'h0000_00FF, 32'hFFFF_FFFF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] din [3];
  logic        wr [3];
  logic        rd [3];
  logic        full_o [3];
  logic        af_o [3];
  logic        empty_o [3];
  logic        ae_o [3];
  logic        ovf_o [3];
  logic        unf_o [3];
  logic [7:0]  dout0, dout1;
  logic [31:0] dout2;
  logic [4:0]  cnt0, cnt1;
  logic [3:0]  cnt2;

  sync_fifo_ext #(.data_width(8), .add_width(4), .fwft(1'b0), .af_thresh(14), .ae_thresh(2)) u0 (
    .clk(clk), .rst(rst), .data_in(din[0][7:0]), .wr_en(wr[0]), .full(full_o[0]),
    .almost_full(af_o[0]), .data_out(dout0), .rd_en(rd[0]), .empty(empty_o[0]),
    .almost_empty(ae_o[0]), .count(cnt0), .overflow(ovf_o[0]), .underflow(unf_o[0]));

  sync_fifo_ext #(.data_width(8), .add_width(4), .fwft(1'b1), .af_thresh(14), .ae_thresh(2)) u1 (
    .clk(clk), .rst(rst), .data_in(din[1][7:0]), .wr_en(wr[1]), .full(full_o[1]),
    .almost_full(af_o[1]), .data_out(dout1), .rd_en(rd[1]), .empty(empty_o[1]),
    .almost_empty(ae_o[1]), .count(cnt1), .overflow(ovf_o[1]), .underflow(unf_o[1]));

  sync_fifo_ext #(.data_width(32), .add_width(3), .fwft(1'b0), .af_thresh(6), .ae_thresh(1)) u2 (
    .clk(clk), .rst(rst), .data_in(din[2]), .wr_en(wr[2]), .full(full_o[2]),
    .almost_full(af_o[2]), .data_out(dout2), .rd_en(rd[2]), .empty(empty_o[2]),
    .almost_empty(ae_o[2]), .count(cnt2), .overflow(ovf_o[2]), .underflow(unf_o[2]));

  // Reference model: one queue per instance plus expected error pulses.
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  logic        e_ovf [3];
  logic        e_unf [3];

  typedef struct {
    int          inst;
    logic [31:0] data;
  } sb_t;
  sb_t sb [$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  function automatic int msize(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] dout_of(int i);
    case (i)
      0:       return 32'(dout0);
      1:       return 32'(dout1);
      default: return dout2;
    endcase
  endfunction

  function automatic logic [31:0] cnt_of(int i);
    case (i)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d t=%0t got %h expected %h", name, i, $time, act, exp);
    end
  endtask

  // Applies the FIFO rules to the pre-edge inputs and model state.
  task automatic model_edge();
    logic [31:0] v;
    int          sz;
    if (rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
      for (int i = 0; i < 3; i++) begin
        e_ovf[i] = 1'b0;
        e_unf[i] = 1'b0;
        if (!FW[i]) sb.push_back('{inst: i, data: 32'h0});
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        sz       = msize(i);
        e_ovf[i] = wr[i] && (sz == DEP[i]);
        e_unf[i] = rd[i] && (sz == 0);
        if (rd[i] && sz > 0) begin
          case (i)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            default: v = q2.pop_front();
          endcase
          if (!FW[i]) sb.push_back('{inst: i, data: v});
        end
        if (wr[i] && sz < DEP[i]) begin
          v = din[i] & MASK[i];
          case (i)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
          endcase
        end
      end
    end
  endtask

  logic [31:0] last [3];
  bit          got [3];

  always @(negedge clk) begin
    sb_t e;
    int  sz;
    if (mon_en) begin
      for (int i = 0; i < 3; i++) got[i] = 1'b0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("data_out", e.inst, dout_of(e.inst), e.data);
        last[e.inst] = e.data;
        got[e.inst]  = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        sz = msize(i);
        if (!FW[i] && !got[i]) chk("data_out_hold", i, dout_of(i), last[i]);
        if (FW[i] && sz > 0) chk("fwft_head", i, dout_of(i), q1[0]);
        chk("count", i, cnt_of(i), 32'(sz));
        chk("full", i, 32'(full_o[i]), 32'(sz == DEP[i]));
        chk("almost_full", i, 32'(af_o[i]), 32'(sz >= AFT[i]));
        chk("empty", i, 32'(empty_o[i]), 32'(sz == 0));
        chk("almost_empty", i, 32'(ae_o[i]), 32'(sz <= AET[i]));
        chk("overflow", i, 32'(ovf_o[i]), 32'(e_ovf[i]));
        chk("underflow", i, 32'(unf_o[i]), 32'(e_unf[i]));
      end
    end
  end

  task automatic set(int i, bit w, bit r, logic [31:0] d);
    wr[i]  = w;
    rd[i]  = r;
    din[i] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 1'b0;
      rd[i] = 1'b0;
    end
  endtask

  initial begin
    int pw;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 1'b0; rd[i] = 1'b0; din[i] = '0;
      e_ovf[i] = 1'b0; e_unf[i] = 1'b0; last[i] = '0; got[i] = 1'b0;
    end
    tick();
    mon_en = 1'b1;
    rst = 1'b1;
    tick();

    // Fill to full, then one overflowing write.
    for (int k = 1; k <= 16; k++) begin
      set(0, 1'b1, 1'b0, 32'(k));
      tick();
    end
    set(0, 1'b1, 1'b0, 32'hAA);
    tick();
    tick();

    // Drain, then one underflowing read.
    for (int k = 0; k < 17; k++) begin
      set(0, 1'b0, 1'b1, 32'h0);
      tick();
    end
    tick();

    // Steady count of 5 under simultaneous traffic, then simultaneous at full.
    for (int k = 0; k < 5; k++) begin
      set(0, 1'b1, 1'b0, $urandom);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      set(0, 1'b1, 1'b1, $urandom);
      tick();
    end
    for (int k = 0; k < 11; k++) begin
      set(0, 1'b1, 1'b0, $urandom);
      tick();
    end
    set(0, 1'b1, 1'b1, 32'h55);
    tick();
    tick();
    for (int k = 0; k < 16; k++) begin
      set(0, 1'b0, 1'b1, 32'h0);
      tick();
    end

    // First-word-fall-through behaviour.
    set(1, 1'b1, 1'b0, 32'h5A); tick();
    tick();
    set(1, 1'b1, 1'b0, 32'h5B); tick();
    set(1, 1'b0, 1'b1, 32'h0);  tick();
    tick();
    set(1, 1'b0, 1'b1, 32'h0);  tick();
    set(1, 1'b1, 1'b1, 32'h77); tick();
    tick();

    // Reset mid-operation with requests present.
    for (int k = 0; k < 9; k++) begin
      set(0, 1'b1, 1'b0, $urandom);
      tick();
    end
    rst = 1'b1;
    set(0, 1'b1, 1'b1, 32'hEE);
    tick();
    set(0, 1'b1, 1'b0, 32'h3C); tick();
    set(0, 1'b0, 1'b1, 32'h0);  tick();
    tick();

    // 32-bit / depth-8 configuration.
    set(2, 1'b1, 1'b0, 32'hDEAD_BEEF); tick();
    set(2, 1'b1, 1'b0, 32'h1234_5678); tick();
    for (int k = 0; k < 7; k++) begin
      set(2, 1'b1, 1'b0, $urandom);
      tick();
    end
    for (int k = 0; k < 9; k++) begin
      set(2, 1'b0, 1'b1, 32'h0);
      tick();
    end

    // Random traffic alternating fill-biased and drain-biased phases.
    for (int k = 0; k < 800; k++) begin
      pw = ((k / 50) % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 3; i++) begin
        set(i, $urandom_range(0, 99) < pw, $urandom_range(0, 99) >= pw - 10, $urandom);
      end
      if ($urandom_range(0, 249) == 0) rst = 1'b1;
      tick();
    end
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
